// File: rtl/phys_reg_free_list_pkg.sv
// Shared sizing and tag types for the rename free list.
package phys_reg_free_list_pkg;
    localparam int P_REG_NUM    = 64;
    localparam int ARCH_REG_NUM = 32;
    localparam int PW           = $clog2(P_REG_NUM);
    localparam int DEPTH        = P_REG_NUM - ARCH_REG_NUM;
    localparam int PTRW         = $clog2(DEPTH) + 1;

    typedef logic [PW-1:0]   preg_t;
    typedef logic [PTRW-1:0] fl_ptr_t;
endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with a committed shadow
// head so a flush can roll back every speculative allocation in one cycle.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    free_list_deq,
    output logic    free_list_empty,
    output preg_t   deq_preg,
    input  logic    commit_alloc,
    input  logic    commit_free,
    input  preg_t   commit_free_preg,
    input  logic    flush,
    output fl_ptr_t free_count,
    output logic    overflow_err
);
    localparam fl_ptr_t LP_DEPTH = fl_ptr_t'(DEPTH);

    preg_t   r_mem [DEPTH];
    fl_ptr_t r_head;
    fl_ptr_t r_tail;
    fl_ptr_t r_commit_head;
    logic    r_overflow;

    fl_ptr_t w_count;
    logic    w_empty;
    logic    w_full;
    logic    w_deq;
    logic    w_enq;
    logic    w_commit_adv;
    fl_ptr_t w_commit_head_next;

    assign w_count      = r_tail - r_head;
    assign w_empty      = (w_count == '0);
    assign w_full       = (w_count == LP_DEPTH);
    assign w_deq        = free_list_deq && !w_empty && !flush;
    assign w_enq        = commit_free && !w_full;
    // The shadow only tracks allocations already handed out.
    assign w_commit_adv = commit_alloc && (r_commit_head != r_head);
    assign w_commit_head_next = r_commit_head + fl_ptr_t'(w_commit_adv);

    assign free_list_empty = w_empty;
    assign free_count      = w_count;
    assign overflow_err    = r_overflow;
    assign deq_preg        = w_empty ? '0 : r_mem[r_head[PTRW-2:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= preg_t'(ARCH_REG_NUM + i);
            end
            r_head        <= '0;
            r_commit_head <= '0;
            r_tail        <= LP_DEPTH;
            r_overflow    <= 1'b0;
        end else begin
            if (w_enq) begin
                r_mem[r_tail[PTRW-2:0]] <= commit_free_preg;
                r_tail <= r_tail + 1'b1;
            end
            if (commit_free && w_full) begin
                r_overflow <= 1'b1;
            end
            r_commit_head <= w_commit_head_next;
            if (flush) begin
                r_head <= w_commit_head_next;
            end else if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
        end
    end

    a_count_le_depth: assert property (
        @(posedge clk) disable iff (rst) w_count <= LP_DEPTH
    );
    a_ptr_order: assert property (
        @(posedge clk) disable iff (rst)
        fl_ptr_t'(r_head - r_commit_head) <= fl_ptr_t'(r_tail - r_commit_head)
    );
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: drain, reclaim, flush rollback,
// pointer wrap and overflow flag.
module tb_phys_reg_free_list;
    import phys_reg_free_list_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    logic    free_list_deq;
    logic    free_list_empty;
    preg_t   deq_preg;
    logic    commit_alloc;
    logic    commit_free;
    preg_t   commit_free_preg;
    logic    flush;
    fl_ptr_t free_count;
    logic    overflow_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    phys_reg_free_list dut (
        .clk              (clk),
        .rst              (rst),
        .free_list_deq    (free_list_deq),
        .free_list_empty  (free_list_empty),
        .deq_preg         (deq_preg),
        .commit_alloc     (commit_alloc),
        .commit_free      (commit_free),
        .commit_free_preg (commit_free_preg),
        .flush            (flush),
        .free_count       (free_count),
        .overflow_err     (overflow_err)
    );

    task automatic idle_inputs();
        free_list_deq    = 1'b0;
        commit_alloc     = 1'b0;
        commit_free      = 1'b0;
        commit_free_preg = '0;
        flush            = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (free_count !== 6'd32) begin
            tests_failed++;
            $display("FAIL reset_count got %0d want 32", free_count);
        end
        tests_run++;
        if (free_list_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_empty got %b want 0", free_list_empty);
        end
        tests_run++;
        if (deq_preg !== 6'd32) begin
            tests_failed++;
            $display("FAIL reset_preg got %0d want 32", deq_preg);
        end
        tests_run++;
        if (overflow_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ovf got %b want 0", overflow_err);
        end
    endtask

    task automatic test_drain();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            if (deq_preg !== preg_t'(32 + i) || free_list_empty !== 1'b0) begin
                bad++;
                $display("FAIL drain_seq[%0d] got %0d/%b want %0d/0",
                         i, deq_preg, free_list_empty, 32 + i);
            end
            free_list_deq = 1'b1;
            step();
        end
        tests_run++;
        if (bad != 0) tests_failed++;
        tests_run++;
        if (free_list_empty !== 1'b1 || deq_preg !== 6'd0 || free_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL drain_empty got %b/%0d/%0d want 1/0/0",
                     free_list_empty, deq_preg, free_count);
        end
        free_list_deq = 1'b1;
        step();
        tests_run++;
        if (free_list_empty !== 1'b1 || free_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL deq_on_empty got %b/%0d want 1/0",
                     free_list_empty, free_count);
        end
    endtask

    task automatic test_reclaim();
        commit_free      = 1'b1;
        commit_free_preg = 6'd5;
        #1;
        tests_run++;
        if (free_list_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL reclaim_no_bypass got %b want 1", free_list_empty);
        end
        step();
        tests_run++;
        if (free_list_empty !== 1'b0 || deq_preg !== 6'd5 || free_count !== 6'd1) begin
            tests_failed++;
            $display("FAIL reclaim_visible got %b/%0d/%0d want 0/5/1",
                     free_list_empty, deq_preg, free_count);
        end
    endtask

    task automatic test_flush();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if (deq_preg !== preg_t'(32 + i)) begin
                bad++;
                $display("FAIL flush_deq[%0d] got %0d want %0d", i, deq_preg, 32 + i);
            end
            free_list_deq = 1'b1;
            step();
        end
        tests_run++;
        if (bad != 0) tests_failed++;
        commit_alloc = 1'b1;
        step();
        flush = 1'b1;
        step();
        tests_run++;
        if (deq_preg !== 6'd33 || free_count !== 6'd31) begin
            tests_failed++;
            $display("FAIL flush_rollback got %0d/%0d want 33/31", deq_preg, free_count);
        end
    endtask

    task automatic test_flush_deq();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            free_list_deq = 1'b1;
            step();
        end
        commit_alloc = 1'b1;
        step();
        flush         = 1'b1;
        free_list_deq = 1'b1;
        commit_alloc  = 1'b1;
        step();
        tests_run++;
        if (deq_preg !== 6'd34 || free_count !== 6'd30) begin
            tests_failed++;
            $display("FAIL flush_with_deq got %0d/%0d want 34/30", deq_preg, free_count);
        end
    endtask

    task automatic test_wrap();
        int bad = 0;
        int exp;
        do_reset();
        free_list_deq = 1'b1;
        commit_alloc  = 1'b1;
        step();
        for (int k = 0; k < 40; k++) begin
            exp = (k < 31) ? (33 + k) : (9 + k);
            free_list_deq    = 1'b1;
            commit_alloc     = 1'b1;
            commit_free      = 1'b1;
            commit_free_preg = preg_t'((40 + k) % 64);
            #1;
            if (deq_preg !== preg_t'(exp) || free_count !== 6'd31) begin
                bad++;
                $display("FAIL wrap[%0d] got %0d/%0d want %0d/31",
                         k, deq_preg, free_count, exp);
            end
            step();
        end
        tests_run++;
        if (bad != 0) tests_failed++;
        tests_run++;
        if (deq_preg !== 6'd49 || free_count !== 6'd31 || overflow_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_end got %0d/%0d/%b want 49/31/0",
                     deq_preg, free_count, overflow_err);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        commit_free      = 1'b1;
        commit_free_preg = 6'd7;
        step();
        tests_run++;
        if (overflow_err !== 1'b1 || free_count !== 6'd32 || deq_preg !== 6'd32) begin
            tests_failed++;
            $display("FAIL ovf_set got %b/%0d/%0d want 1/32/32",
                     overflow_err, free_count, deq_preg);
        end
        free_list_deq = 1'b1;
        step();
        tests_run++;
        if (overflow_err !== 1'b1 || deq_preg !== 6'd33) begin
            tests_failed++;
            $display("FAIL ovf_sticky got %b/%0d want 1/33", overflow_err, deq_preg);
        end
        do_reset();
        tests_run++;
        if (overflow_err !== 1'b0 || free_count !== 6'd32) begin
            tests_failed++;
            $display("FAIL ovf_clear got %b/%0d want 0/32", overflow_err, free_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_drain();
        test_reclaim();
        test_flush();
        test_flush_deq();
        test_wrap();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
